hex_scroll_controller: RTL and testbench



---
 rtl/hex_scroll_controller.sv | 191 +++++++++++++++++++
 tb/tb_hex_scroll_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_controller.sv
// hex_scroll_controller
//
// Sequencer for the 4-digit HEX rotating-message datapath. A single-clock
// design that produces a one-cycle advance strobe at a switch-selectable
// rate and keeps the rotation position consumed by shifter_decoder.
//
// Ports:
//   CLOCK_50  in   1          system clock (single clock domain)
//   resetn    in   1          asynchronous, active-low reset
//   run       in   1          switch, 1 = auto-scroll, 0 = paused (async)
//   dir       in   1          switch, 0 = increment, 1 = decrement (async)
//   speed     in   2          switches, period = TICK_COUNT >> speed (async)
//   step_n    in   1          pushbutton, active-low, one advance per press
//                             while paused (async)
//   pos       out  POS_WIDTH  current rotation position
//   tick      out  1          one-cycle pulse, coincident with new pos
//   state     out  2          FSM state for LEDs: 00 PAUSE, 01 RUN, 10 STEP
//
// Parameters:
//   TICK_COUNT  clock cycles per advance at speed 0 (>= 8)
//   CNT_WIDTH   rate counter width, must hold TICK_COUNT-1
//   POS_WIDTH   rotation position width
//   NUM_POS     number of positions, NUM_POS <= 2**POS_WIDTH

module hex_scroll_controller #(
  parameter int TICK_COUNT = 50000000,
  parameter int CNT_WIDTH  = 26,
  parameter int POS_WIDTH  = 2,
  parameter int NUM_POS    = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 dir,
  input  logic [1:0]           speed,
  input  logic                 step_n,
  output logic [POS_WIDTH-1:0] pos,
  output logic                 tick,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_PAUSE = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10
  } state_t;

  localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(NUM_POS - 1);

  // Synchronizer stages and the step history flop
  logic                 run_meta;
  logic                 run_s;
  logic                 dir_meta;
  logic                 dir_s;
  logic [1:0]           speed_meta;
  logic [1:0]           speed_s;
  logic                 step_meta;
  logic                 step_s;
  logic                 step_prev;

  // Datapath
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] nxt_count;
  logic [CNT_WIDTH-1:0] limit_m1;
  logic                 terminal;
  logic                 step_event;
  logic                 advance;
  logic [POS_WIDTH-1:0] pos_fwd;
  logic [POS_WIDTH-1:0] pos_back;
  logic [POS_WIDTH-1:0] nxt_pos;

  // FSM
  state_t               cur_state;
  state_t               nxt_state;

  // Two-flop synchronizers for every board input. step_prev is the extra
  // history flop used to find the falling edge of the synchronized key.
  // Idle values match a released key and switches at zero.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      run_meta   <= 1'b0;
      run_s      <= 1'b0;
      dir_meta   <= 1'b0;
      dir_s      <= 1'b0;
      speed_meta <= 2'b00;
      speed_s    <= 2'b00;
      step_meta  <= 1'b1;
      step_s     <= 1'b1;
      step_prev  <= 1'b1;
    end else begin
      run_meta   <= run;
      run_s      <= run_meta;
      dir_meta   <= dir;
      dir_s      <= dir_meta;
      speed_meta <= speed;
      speed_s    <= speed_meta;
      step_meta  <= step_n;
      step_s     <= step_meta;
      step_prev  <= step_s;
    end
  end

  // One event per press: high only in the cycle the synchronized key falls.
  assign step_event = step_prev & ~step_s;

  // The period is recomputed every cycle. Using >= rather than == means a
  // speed-up that leaves the counter past the new limit fires at once
  // instead of running round the whole counter range.
  always_comb begin
    limit_m1 = CNT_WIDTH'((TICK_COUNT >> speed_s) - 1);
    terminal = (count >= limit_m1);
  end

  // Wrap-around neighbours of the current position in both directions.
  always_comb begin
    pos_fwd  = (pos == POS_LAST) ? '0 : pos + 1'b1;
    pos_back = (pos == '0) ? POS_LAST : pos - 1'b1;
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cur_state <= S_PAUSE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state and datapath control. In RUN a falling run switch takes
  // priority over a terminal count, so pausing never produces a late tick.
  // In PAUSE a rising run switch takes priority over a step press.
  always_comb begin
    nxt_state = cur_state;
    nxt_count = count;
    advance   = 1'b0;
    case (cur_state)
      S_PAUSE: begin
        nxt_count = '0;
        if (run_s) begin
          nxt_state = S_RUN;
        end else if (step_event) begin
          nxt_state = S_STEP;
        end
      end
      S_RUN: begin
        if (!run_s) begin
          nxt_state = S_PAUSE;
          nxt_count = '0;
        end else if (terminal) begin
          nxt_count = '0;
          advance   = 1'b1;
        end else begin
          nxt_count = count + 1'b1;
        end
      end
      S_STEP: begin
        nxt_count = '0;
        advance   = 1'b1;
        nxt_state = S_PAUSE;
      end
      default: begin
        nxt_count = '0;
        nxt_state = S_PAUSE;
      end
    endcase
  end

  // Direction is taken from the synchronized switch in the advancing cycle.
  always_comb begin
    nxt_pos = pos;
    if (advance) begin
      nxt_pos = dir_s ? pos_back : pos_fwd;
    end
  end

  // Registered outputs: tick and the new position leave on the same edge.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      pos   <= '0;
      tick  <= 1'b0;
    end else begin
      count <= nxt_count;
      pos   <= nxt_pos;
      tick  <= advance;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_hex_scroll_controller.sv
// tb_hex_scroll_controller
//
// Bench for hex_scroll_controller with TICK_COUNT=16, NUM_POS=4. Every cycle
// the outputs are compared with a reference model built from a history of
// sampled pin values and an elapsed-cycle count. Hand-derived vectors and
// short scripted sequences cover wrap-around, step presses, speed changes,
// pause priority and asynchronous reset.

module tb_hex_scroll_controller;

  localparam int TICK = 16;
  localparam int CW   = 5;
  localparam int PW   = 2;
  localparam int NP   = 4;

  logic          CLOCK_50 = 1'b0;
  logic          resetn   = 1'b1;
  logic          run      = 1'b0;
  logic          dir      = 1'b0;
  logic [1:0]    speed    = 2'b00;
  logic          step_n   = 1'b1;
  logic [PW-1:0] pos;
  logic          tick;
  logic [1:0]    state;

  hex_scroll_controller #(
    .TICK_COUNT(TICK),
    .CNT_WIDTH (CW),
    .POS_WIDTH (PW),
    .NUM_POS   (NP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .run     (run),
    .dir     (dir),
    .speed   (speed),
    .step_n  (step_n),
    .pos     (pos),
    .tick    (tick),
    .state   (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;
  int dut_ticks   = 0;

  typedef struct {
    logic       run;
    logic       dir;
    logic [1:0] speed;
    logic       step_n;
  } pins_t;

  // Reference model: mode 0 pause, 1 run, 2 step (same codes as the LEDs).
  // hist[0] holds the pins seen at the previous edge, hist[1] two edges ago
  // (what the design acts on), hist[2] three edges ago (for the key edge).
  pins_t hist[3];
  int    m_pos;
  int    m_tick;
  int    m_mode;
  int    m_elapsed;

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) hist[i] = '{1'b0, 1'b0, 2'b00, 1'b1};
    m_pos     = 0;
    m_tick    = 0;
    m_mode    = 0;
    m_elapsed = 0;
  endfunction

  function automatic void modelAdvance(logic d);
    m_pos  = d ? (m_pos + NP - 1) % NP : (m_pos + 1) % NP;
    m_tick = 1;
  endfunction

  function automatic void modelEdge(pins_t now);
    pins_t seen;
    pins_t older;
    int    period;
    if (!resetn) return;
    seen   = hist[1];
    older  = hist[2];
    period = TICK >> seen.speed;
    m_tick = 0;
    case (m_mode)
      0: begin
        if (seen.run) m_mode = 1;
        else if (older.step_n && !seen.step_n) m_mode = 2;
      end
      1: begin
        if (!seen.run) begin
          m_mode    = 0;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed >= period) begin
            m_elapsed = 0;
            modelAdvance(seen.dir);
          end
        end
      end
      default: begin
        modelAdvance(seen.dir);
        m_mode = 0;
      end
    endcase
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = now;
  endfunction

  task automatic checkOutput(input string name);
    vectors++;
    if (pos !== PW'(m_pos) || tick !== m_tick[0] || state !== m_mode[1:0]) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got pos=%0d tick=%b state=%b, model pos=%0d tick=%0d state=%0d",
               name, $time, pos, tick, state, m_pos, m_tick, m_mode);
    end
  endtask

  task automatic checkExpect(input string name, input int e_pos, input int e_tick, input int e_state);
    vectors++;
    if (pos !== PW'(e_pos) || tick !== e_tick[0] || state !== e_state[1:0]) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got pos=%0d tick=%b state=%b, expected pos=%0d tick=%0d state=%0d",
               name, $time, pos, tick, state, e_pos, e_tick, e_state);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One clock: drive pins between edges, step the model on the edge, then
  // compare shortly after it.
  task automatic applyStimulus(input logic r, input logic d, input logic [1:0] sp, input logic st);
    pins_t p;
    run    = r;
    dir    = d;
    speed  = sp;
    step_n = st;
    p      = '{r, d, sp, st};
    @(posedge CLOCK_50);
    modelEdge(p);
    #1;
    checkOutput("cycle");
    if (tick === 1'b1) dut_ticks++;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic doReset();
    #1;
    resetn = 1'b0;
    #1;
    modelReset();
    checkExpect("async_reset", 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic       run;
    logic       dir;
    logic [1:0] speed;
    logic       step_n;
    int         cycles;
    int         e_pos;
    int         e_tick;
    int         e_state;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic       r;
    logic       d;
    logic [1:0] sp;
    logic       st;

    // Rows count edges after reset release; rows 0-7 increment at speed 0,
    // rows 8-12 decrement at speed 2.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b1,  2, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1,  1, 0, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 15, 0, 0, 1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1,  1, 1, 1, 1};
    vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1,  1, 1, 0, 1};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b1, 15, 2, 1, 1};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 1'b1, 16, 3, 1, 1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 1'b1, 16, 0, 1, 1};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 1'b1,  3, 0, 0, 1};
    vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b1,  1, 3, 1, 1};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 1'b1,  4, 2, 1, 1};
    vecs[11] = '{1'b1, 1'b1, 2'd2, 1'b1,  4, 1, 1, 1};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 1'b1,  4, 0, 1, 1};

    #2;
    doReset();

    for (int i = 0; i < 13; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++)
        applyStimulus(vecs[i].run, vecs[i].dir, vecs[i].speed, vecs[i].step_n);
      checkExpect($sformatf("vec%0d", i), vecs[i].e_pos, vecs[i].e_tick, vecs[i].e_state);
    end

    // Step presses while paused: two presses to reach pos 2, then a timed one.
    $display("[TB] step press sequence");
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
      repeat (6) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    end
    checkExpect("step_setup", 2, 0, 0);
    dut_ticks = 0;
    repeat (3) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    checkExpect("step_state", 2, 0, 2);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkExpect("step_tick", 3, 1, 0);
    repeat (20) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkCount("step_single", dut_ticks, 1);
    dut_ticks = 0;
    repeat (40) applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkCount("step_hold", dut_ticks, 1);
    checkExpect("step_hold_pos", 0, 0, 0);

    // Speed raised mid-count: counter past the new limit fires immediately.
    $display("[TB] speed change sequence");
    doReset();
    repeat (15) applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkExpect("speed_pre", 0, 0, 1);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
    checkExpect("speed_sync", 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
    checkExpect("speed_fire", 1, 1, 1);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
    checkExpect("speed_gap", 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
    checkExpect("speed_2nd", 2, 1, 1);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'd3, 1'b1);
    checkExpect("speed_3rd", 3, 1, 1);

    // Pause arriving on the terminal cycle wins; re-run restarts the period.
    $display("[TB] pause priority sequence");
    doReset();
    repeat (16) applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkExpect("pause_pre", 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    checkExpect("pause_wins", 0, 0, 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
    dut_ticks = 0;
    repeat (18) applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkCount("rerun_quiet", dut_ticks, 0);
    checkExpect("rerun_state", 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkExpect("rerun_tick", 1, 1, 1);

    // Reset mid-count at pos 3, then normal operation from position 0.
    $display("[TB] mid-run reset sequence");
    doReset();
    repeat (56) applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkExpect("prereset", 3, 0, 1);
    doReset();
    dut_ticks = 0;
    repeat (18) applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkCount("postreset_quiet", dut_ticks, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1);
    checkExpect("postreset_tick", 1, 1, 1);

    // Randomized switches, key presses and occasional resets.
    $display("[TB] random sequence");
    doReset();
    r  = 1'b0;
    d  = 1'b0;
    sp = 2'd0;
    st = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39, 0) == 0) r = ~r;
      if ($urandom_range(29, 0) == 0) d = ~d;
      if ($urandom_range(49, 0) == 0) sp = 2'($urandom_range(3, 0));
      if (st) begin
        if ($urandom_range(19, 0) == 0) st = 1'b0;
      end else begin
        if ($urandom_range(3, 0) == 0) st = 1'b1;
      end
      if ($urandom_range(399, 0) == 0) doReset();
      applyStimulus(r, d, sp, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
